// File: rtl/qdr_multi_sniffer.sv
// qdr_multi_sniffer: arbitrates NPORTS slave ports onto one QDR controller
// command port, tracks outstanding reads in a tag FIFO so in-order read
// returns are steered to the owning port, and sequences the QDR reset pulse.
module qdr_multi_sniffer #(
   parameter int NPORTS         = 2,
   parameter int QDR_DATA_WIDTH = 18,
   parameter int QDR_BW_WIDTH   = 2,
   parameter int QDR_ADDR_WIDTH = 22,
   parameter int RD_DEPTH       = 16,
   parameter int RST_CYCLES     = 64
) (
   input  logic                                  qdr_clk,
   input  logic                                  qdr_rst_n,
   input  logic [NPORTS*QDR_ADDR_WIDTH-1:0]      slave_addr,
   input  logic [NPORTS-1:0]                     slave_wr_strb,
   input  logic [NPORTS*2*QDR_DATA_WIDTH-1:0]    slave_wr_data,
   input  logic [NPORTS*2*QDR_BW_WIDTH-1:0]      slave_wr_be,
   input  logic [NPORTS-1:0]                     slave_rd_strb,
   output logic [NPORTS-1:0]                     slave_ack,
   output logic [2*QDR_DATA_WIDTH-1:0]           slave_rd_data,
   output logic [NPORTS-1:0]                     slave_rd_dvld,
   output logic [QDR_ADDR_WIDTH-1:0]             master_addr,
   output logic                                  master_wr_strb,
   output logic [2*QDR_DATA_WIDTH-1:0]           master_wr_data,
   output logic [2*QDR_BW_WIDTH-1:0]             master_wr_be,
   output logic                                  master_rd_strb,
   input  logic [2*QDR_DATA_WIDTH-1:0]           master_rd_data,
   input  logic                                  master_rd_dvld,
   input  logic                                  phy_rdy,
   input  logic                                  cal_fail,
   input  logic                                  prio_mode,
   input  logic                                  reset_req,
   output logic                                  rd_err,
   output logic                                  qdr_reset
);

   localparam int DW     = 2*QDR_DATA_WIDTH;
   localparam int BW     = 2*QDR_BW_WIDTH;
   localparam int AW     = QDR_ADDR_WIDTH;
   localparam int TAG_W  = (NPORTS > 1) ? $clog2(NPORTS) : 1;
   localparam int PTR_W  = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
   localparam int CNT_W  = PTR_W + 1;
   localparam int RCNT_W = $clog2(RST_CYCLES + 2);

   logic [NPORTS-1:0] ack_q, ack_d;
   logic [NPORTS-1:0] rd_dvld_q, rd_dvld_d;
   logic [DW-1:0]     rd_data_q, rd_data_d;
   logic [AW-1:0]     maddr_q, maddr_d;
   logic [DW-1:0]     mwdata_q, mwdata_d;
   logic [BW-1:0]     mbe_q, mbe_d;
   logic              mwr_q, mwr_d;
   logic              mrd_q, mrd_d;
   logic              rd_err_q, rd_err_d;
   logic [RCNT_W-1:0] rst_cnt_q, rst_cnt_d;
   logic              reset_req_q;
   logic [TAG_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [TAG_W-1:0]  tag_mem_q [RD_DEPTH];

   logic              rst_edge, qdr_reset_i, blk, fifo_full, grant_en;
   logic [NPORTS-1:0] elig;
   logic              gnt_vld, gnt_is_wr, push, pop, orphan;
   logic [TAG_W-1:0]  gnt_idx, pop_tag;
   logic [AW-1:0]     sel_addr;
   logic [DW-1:0]     sel_wdata;
   logic [BW-1:0]     sel_be;
   int                scan;

   // Blocking conditions and per-port eligibility (a port acked last cycle sits out)
   always_comb begin
      rst_edge    = reset_req & ~reset_req_q;
      qdr_reset_i = (rst_cnt_q != '0);
      blk         = qdr_reset_i | rst_edge;
      fifo_full   = (cnt_q == CNT_W'(RD_DEPTH));
      elig        = ~ack_q & (slave_wr_strb | (slave_rd_strb & {NPORTS{~fifo_full}}));
      grant_en    = phy_rdy & ~cal_fail & ~blk;
   end

   // Arbiter: scan starts at port 0 (fixed) or after the last grant (round-robin)
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      scan    = 0;
      if (grant_en) begin
         for (int i = 0; i < NPORTS; i++) begin
            scan = prio_mode ? i : (int'(rr_ptr_q) + i) % NPORTS;
            for (int j = 0; j < NPORTS; j++) begin
               if (!gnt_vld && (j == scan) && elig[j]) begin
                  gnt_vld = 1'b1;
                  gnt_idx = TAG_W'(j);
               end
            end
         end
      end
   end

   // Mux the granted port's command fields; write wins over a simultaneous read
   always_comb begin
      gnt_is_wr = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_be    = '0;
      ack_d     = '0;
      for (int j = 0; j < NPORTS; j++) begin
         if (gnt_vld && (int'(gnt_idx) == j)) begin
            gnt_is_wr = slave_wr_strb[j];
            sel_addr  = slave_addr[j*AW +: AW];
            sel_wdata = slave_wr_data[j*DW +: DW];
            sel_be    = slave_wr_be[j*BW +: BW];
            ack_d[j]  = 1'b1;
         end
      end
   end

   // Next-state for command outputs, tag FIFO, read return and reset pulse
   always_comb begin
      push     = gnt_vld & ~gnt_is_wr;
      pop      = master_rd_dvld & ~blk & (cnt_q != '0);
      orphan   = master_rd_dvld & ~blk & (cnt_q == '0);
      pop_tag  = tag_mem_q[rd_ptr_q];

      maddr_d  = gnt_vld ? sel_addr  : maddr_q;
      mwdata_d = gnt_vld ? sel_wdata : mwdata_q;
      mbe_d    = gnt_vld ? sel_be    : mbe_q;
      mwr_d    = gnt_vld & gnt_is_wr;
      mrd_d    = push;
      rr_ptr_d = gnt_vld ? TAG_W'((int'(gnt_idx) + 1) % NPORTS) : rr_ptr_q;

      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      cnt_d    = cnt_q;
      if (push && !pop)
         cnt_d = cnt_q + CNT_W'(1);
      else if (pop && !push)
         cnt_d = cnt_q - CNT_W'(1);
      if (blk) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end

      rd_data_d = pop ? master_rd_data : rd_data_q;
      rd_dvld_d = '0;
      for (int j = 0; j < NPORTS; j++)
         rd_dvld_d[j] = pop && (int'(pop_tag) == j);
      rd_err_d = rd_err_q | orphan;

      if (rst_edge)
         rst_cnt_d = RCNT_W'(RST_CYCLES);
      else if (qdr_reset_i)
         rst_cnt_d = rst_cnt_q - RCNT_W'(1);
      else
         rst_cnt_d = rst_cnt_q;
   end

   // State registers; reset loads one extra count so qdr_reset spans RST_CYCLES full cycles after release
   always_ff @(posedge qdr_clk) begin
      if (!qdr_rst_n) begin
         ack_q       <= '0;
         rd_dvld_q   <= '0;
         rd_data_q   <= '0;
         maddr_q     <= '0;
         mwdata_q    <= '0;
         mbe_q       <= '0;
         mwr_q       <= 1'b0;
         mrd_q       <= 1'b0;
         rd_err_q    <= 1'b0;
         rst_cnt_q   <= RCNT_W'(RST_CYCLES + 1);
         reset_req_q <= 1'b0;
         rr_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
      end else begin
         ack_q       <= ack_d;
         rd_dvld_q   <= rd_dvld_d;
         rd_data_q   <= rd_data_d;
         maddr_q     <= maddr_d;
         mwdata_q    <= mwdata_d;
         mbe_q       <= mbe_d;
         mwr_q       <= mwr_d;
         mrd_q       <= mrd_d;
         rd_err_q    <= rd_err_d;
         rst_cnt_q   <= rst_cnt_d;
         reset_req_q <= reset_req;
         rr_ptr_q    <= rr_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
      end
   end

   // Tag storage: owning port of each outstanding read, in issue order
   always_ff @(posedge qdr_clk) begin
      if (qdr_rst_n && push)
         tag_mem_q[wr_ptr_q] <= gnt_idx;
   end

   assign slave_ack      = ack_q;
   assign slave_rd_dvld  = rd_dvld_q;
   assign slave_rd_data  = rd_data_q;
   assign master_addr    = maddr_q;
   assign master_wr_data = mwdata_q;
   assign master_wr_be   = mbe_q;
   assign master_wr_strb = mwr_q;
   assign master_rd_strb = mrd_q;
   assign rd_err         = rd_err_q;
   assign qdr_reset      = qdr_reset_i;

endmodule

// File: tb/tb_qdr_multi_sniffer.sv
// Directed bench for qdr_multi_sniffer with default parameters (2 ports).
module tb_qdr_multi_sniffer;

   localparam logic [21:0] A0 = 22'h0000A0;
   localparam logic [21:0] A1 = 22'h0001B1;
   localparam logic [35:0] D0 = 36'h0AAAA0000;
   localparam logic [35:0] D1 = 36'h155551111;
   localparam logic [35:0] RX = 36'h012345678;
   localparam logic [35:0] D2 = 36'h09ABCDEF0;
   localparam logic [35:0] E1 = 36'h111111111;
   localparam logic [35:0] E2 = 36'h222222222;
   localparam logic [35:0] E3 = 36'h333333333;
   localparam logic [35:0] OR = 36'hFFFFFFFFF;
   localparam logic [35:0] R4 = 36'h0ABCABCAB;

   logic        qdr_clk = 1'b0;
   logic        qdr_rst_n;
   logic [43:0] slave_addr;
   logic [1:0]  slave_wr_strb;
   logic [71:0] slave_wr_data;
   logic [7:0]  slave_wr_be;
   logic [1:0]  slave_rd_strb;
   logic [1:0]  slave_ack;
   logic [35:0] slave_rd_data;
   logic [1:0]  slave_rd_dvld;
   logic [21:0] master_addr;
   logic        master_wr_strb;
   logic [35:0] master_wr_data;
   logic [3:0]  master_wr_be;
   logic        master_rd_strb;
   logic [35:0] master_rd_data;
   logic        master_rd_dvld;
   logic        phy_rdy, cal_fail, prio_mode, reset_req;
   logic        rd_err, qdr_reset;

   int n_cmp = 0;
   int n_err = 0;

   qdr_multi_sniffer dut (
      .qdr_clk(qdr_clk), .qdr_rst_n(qdr_rst_n),
      .slave_addr(slave_addr), .slave_wr_strb(slave_wr_strb),
      .slave_wr_data(slave_wr_data), .slave_wr_be(slave_wr_be),
      .slave_rd_strb(slave_rd_strb), .slave_ack(slave_ack),
      .slave_rd_data(slave_rd_data), .slave_rd_dvld(slave_rd_dvld),
      .master_addr(master_addr), .master_wr_strb(master_wr_strb),
      .master_wr_data(master_wr_data), .master_wr_be(master_wr_be),
      .master_rd_strb(master_rd_strb), .master_rd_data(master_rd_data),
      .master_rd_dvld(master_rd_dvld), .phy_rdy(phy_rdy), .cal_fail(cal_fail),
      .prio_mode(prio_mode), .reset_req(reset_req), .rd_err(rd_err),
      .qdr_reset(qdr_reset)
   );

   always #5 qdr_clk = ~qdr_clk;

   typedef struct {
      logic [1:0]  wr, rd;
      logic        prio, dv;
      logic [35:0] dvdata;
      logic [1:0]  ack;
      logic        mwr, mrd;
      logic [21:0] addr;
      logic [35:0] wdata;
      logic [1:0]  dvld;
      logic [35:0] rdata;
      logic        err;
   } vec_t;

   vec_t tbl [26];

   function automatic vec_t mk(input logic [1:0] wr, input logic [1:0] rd, input logic prio,
                               input logic dv, input logic [35:0] dvdata, input logic [1:0] ack,
                               input logic mwr, input logic mrd, input logic [21:0] addr,
                               input logic [35:0] wdata, input logic [1:0] dvld,
                               input logic [35:0] rdata, input logic err);
      vec_t v;
      v.wr = wr; v.rd = rd; v.prio = prio; v.dv = dv; v.dvdata = dvdata;
      v.ack = ack; v.mwr = mwr; v.mrd = mrd; v.addr = addr; v.wdata = wdata;
      v.dvld = dvld; v.rdata = rdata; v.err = err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge qdr_clk);
      #1;
   endtask

   // Release reset and measure the qdr_reset tail; no acks may appear meanwhile
   task automatic release_reset(input string name);
      int hi;
      hi = 0;
      qdr_rst_n = 1'b1;
      for (int k = 0; k < 200; k++) begin
         step();
         if (qdr_reset) begin
            hi++;
            chk({name, "_ack_in_rst"}, 64'(slave_ack), 64'(0));
         end else begin
            break;
         end
      end
      chk({name, "_len"}, 64'(hi), 64'(64));
      chk({name, "_ack_at_end"}, 64'(slave_ack), 64'(0));
   endtask

   initial begin
      int n;
      int hi;

      tbl[0]  = mk(2'b11, 2'b00, 0, 0, '0, 2'b01, 1, 0, A0, D0, 2'b00, '0, 0);
      tbl[1]  = mk(2'b11, 2'b00, 0, 0, '0, 2'b10, 1, 0, A1, D1, 2'b00, '0, 0);
      tbl[2]  = mk(2'b11, 2'b00, 0, 0, '0, 2'b01, 1, 0, A0, D0, 2'b00, '0, 0);
      tbl[3]  = mk(2'b11, 2'b00, 0, 0, '0, 2'b10, 1, 0, A1, D1, 2'b00, '0, 0);
      tbl[4]  = mk(2'b11, 2'b00, 1, 0, '0, 2'b01, 1, 0, A0, D0, 2'b00, '0, 0);
      tbl[5]  = mk(2'b11, 2'b00, 1, 0, '0, 2'b10, 1, 0, A1, D1, 2'b00, '0, 0);
      tbl[6]  = mk(2'b11, 2'b00, 1, 0, '0, 2'b01, 1, 0, A0, D0, 2'b00, '0, 0);
      tbl[7]  = mk(2'b11, 2'b00, 1, 0, '0, 2'b10, 1, 0, A1, D1, 2'b00, '0, 0);
      tbl[8]  = mk(2'b10, 2'b00, 1, 0, '0, 2'b00, 0, 0, A1, D1, 2'b00, '0, 0);
      tbl[9]  = mk(2'b10, 2'b00, 1, 0, '0, 2'b10, 1, 0, A1, D1, 2'b00, '0, 0);
      tbl[10] = mk(2'b10, 2'b00, 1, 0, '0, 2'b00, 0, 0, A1, D1, 2'b00, '0, 0);
      tbl[11] = mk(2'b01, 2'b10, 0, 0, '0, 2'b01, 1, 0, A0, D0, 2'b00, '0, 0);
      tbl[12] = mk(2'b01, 2'b10, 0, 0, '0, 2'b10, 0, 1, A1, D1, 2'b00, '0, 0);
      tbl[13] = mk(2'b00, 2'b00, 0, 1, RX, 2'b00, 0, 0, A1, D1, 2'b10, RX, 0);
      tbl[14] = mk(2'b01, 2'b01, 0, 0, '0, 2'b01, 1, 0, A0, D0, 2'b00, RX, 0);
      tbl[15] = mk(2'b00, 2'b01, 0, 0, '0, 2'b00, 0, 0, A0, D0, 2'b00, RX, 0);
      tbl[16] = mk(2'b00, 2'b01, 0, 0, '0, 2'b01, 0, 1, A0, D0, 2'b00, RX, 0);
      tbl[17] = mk(2'b00, 2'b00, 0, 1, D2, 2'b00, 0, 0, A0, D0, 2'b01, D2, 0);
      tbl[18] = mk(2'b00, 2'b11, 0, 0, '0, 2'b10, 0, 1, A1, D1, 2'b00, D2, 0);
      tbl[19] = mk(2'b00, 2'b11, 0, 0, '0, 2'b01, 0, 1, A0, D0, 2'b00, D2, 0);
      tbl[20] = mk(2'b00, 2'b10, 0, 0, '0, 2'b10, 0, 1, A1, D1, 2'b00, D2, 0);
      tbl[21] = mk(2'b00, 2'b00, 0, 1, E1, 2'b00, 0, 0, A1, D1, 2'b10, E1, 0);
      tbl[22] = mk(2'b00, 2'b00, 0, 1, E2, 2'b00, 0, 0, A1, D1, 2'b01, E2, 0);
      tbl[23] = mk(2'b00, 2'b00, 0, 1, E3, 2'b00, 0, 0, A1, D1, 2'b10, E3, 0);
      tbl[24] = mk(2'b00, 2'b00, 0, 0, '0, 2'b00, 0, 0, A1, D1, 2'b00, E3, 0);
      tbl[25] = mk(2'b00, 2'b00, 0, 1, OR, 2'b00, 0, 0, A1, D1, 2'b00, E3, 1);

      slave_addr     = {A1, A0};
      slave_wr_data  = {D1, D0};
      slave_wr_be    = {4'hC, 4'h3};
      slave_wr_strb  = 2'b11;
      slave_rd_strb  = 2'b00;
      master_rd_data = '0;
      master_rd_dvld = 1'b0;
      phy_rdy        = 1'b1;
      cal_fail       = 1'b0;
      prio_mode      = 1'b0;
      reset_req      = 1'b0;
      qdr_rst_n      = 1'b0;

      // Reset state with requests pending
      repeat (3) step();
      chk("rst_ack", 64'(slave_ack), 64'(0));
      chk("rst_mwr", 64'(master_wr_strb), 64'(0));
      chk("rst_mrd", 64'(master_rd_strb), 64'(0));
      chk("rst_addr", 64'(master_addr), 64'(0));
      chk("rst_wdata", 64'(master_wr_data), 64'(0));
      chk("rst_dvld", 64'(slave_rd_dvld), 64'(0));
      chk("rst_rdata", 64'(slave_rd_data), 64'(0));
      chk("rst_err", 64'(rd_err), 64'(0));
      chk("rst_qdr_reset", 64'(qdr_reset), 64'(1));
      release_reset("por");

      // Arbitration / read steering table
      for (int i = 0; i < 26; i++) begin
         slave_wr_strb  = tbl[i].wr;
         slave_rd_strb  = tbl[i].rd;
         prio_mode      = tbl[i].prio;
         master_rd_dvld = tbl[i].dv;
         master_rd_data = tbl[i].dvdata;
         step();
         chk($sformatf("v%0d_ack", i), 64'(slave_ack), 64'(tbl[i].ack));
         chk($sformatf("v%0d_mwr", i), 64'(master_wr_strb), 64'(tbl[i].mwr));
         chk($sformatf("v%0d_mrd", i), 64'(master_rd_strb), 64'(tbl[i].mrd));
         chk($sformatf("v%0d_addr", i), 64'(master_addr), 64'(tbl[i].addr));
         chk($sformatf("v%0d_wdata", i), 64'(master_wr_data), 64'(tbl[i].wdata));
         chk($sformatf("v%0d_dvld", i), 64'(slave_rd_dvld), 64'(tbl[i].dvld));
         chk($sformatf("v%0d_rdata", i), 64'(slave_rd_data), 64'(tbl[i].rdata));
         chk($sformatf("v%0d_err", i), 64'(rd_err), 64'(tbl[i].err));
      end
      master_rd_dvld = 1'b0;
      master_rd_data = '0;

      // Fill the tag FIFO: only 16 reads may issue
      slave_wr_strb = 2'b00;
      slave_rd_strb = 2'b01;
      prio_mode     = 1'b0;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (master_rd_strb) n++;
      end
      chk("fill_reads", 64'(n), 64'(16));
      master_rd_dvld = 1'b1;
      master_rd_data = R4;
      step();
      master_rd_dvld = 1'b0;
      chk("full_pop_dvld", 64'(slave_rd_dvld), 64'(2'b01));
      chk("full_pop_data", 64'(slave_rd_data), 64'(R4));
      n = 0;
      for (int k = 0; k < 2; k++) begin
         step();
         if (master_rd_strb) n++;
      end
      chk("refill_read", 64'(n), 64'(1));
      n = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (master_rd_strb) n++;
      end
      chk("full_again", 64'(n), 64'(0));

      // Controller not ready: cal_fail, then phy_rdy low
      slave_rd_strb = 2'b00;
      slave_wr_strb = 2'b11;
      cal_fail      = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("calfail_ack", 64'(slave_ack), 64'(0));
      end
      cal_fail = 1'b0;
      phy_rdy  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("phy_ack", 64'(slave_ack), 64'(0));
      end

      // reset_req pulse, restarted after 20 cycles; phy_rdy returns mid-pulse
      reset_req = 1'b1;
      step();
      chk("pulse_start", 64'(qdr_reset), 64'(1));
      hi = qdr_reset ? 1 : 0;
      for (int k = 0; k < 300; k++) begin
         reset_req      = (hi == 20);
         master_rd_dvld = (hi == 10);
         if (hi == 5) phy_rdy = 1'b1;
         step();
         if (qdr_reset) begin
            hi++;
            chk("pulse_ack", 64'(slave_ack), 64'(0));
            chk("pulse_dvld", 64'(slave_rd_dvld), 64'(0));
         end else begin
            break;
         end
      end
      reset_req      = 1'b0;
      master_rd_dvld = 1'b0;
      chk("pulse_len", 64'(hi), 64'(84));
      chk("pulse_end_ack", 64'(slave_ack), 64'(0));
      step();
      chk("post_pulse_ack", 64'(slave_ack), 64'(2'b10));
      chk("post_pulse_mwr", 64'(master_wr_strb), 64'(1));
      chk("post_pulse_addr", 64'(master_addr), 64'(A1));
      slave_wr_strb = 2'b00;
      step();
      master_rd_dvld = 1'b1;
      step();
      master_rd_dvld = 1'b0;
      chk("flushed_dvld", 64'(slave_rd_dvld), 64'(0));
      chk("err_sticky", 64'(rd_err), 64'(1));

      // Reset asserted with a read outstanding
      slave_rd_strb = 2'b01;
      step();
      chk("mid_read_issue", 64'(master_rd_strb), 64'(1));
      slave_rd_strb = 2'b00;
      qdr_rst_n     = 1'b0;
      step();
      chk("mid_rst_ack", 64'(slave_ack), 64'(0));
      chk("mid_rst_mrd", 64'(master_rd_strb), 64'(0));
      chk("mid_rst_addr", 64'(master_addr), 64'(0));
      chk("mid_rst_rdata", 64'(slave_rd_data), 64'(0));
      chk("mid_rst_err", 64'(rd_err), 64'(0));
      chk("mid_rst_qdr_reset", 64'(qdr_reset), 64'(1));
      master_rd_dvld = 1'b1;
      step();
      master_rd_dvld = 1'b0;
      chk("mid_rst_dvld", 64'(slave_rd_dvld), 64'(0));
      release_reset("mid");
      master_rd_dvld = 1'b1;
      master_rd_data = E1;
      step();
      master_rd_dvld = 1'b0;
      chk("mid_abandon_dvld", 64'(slave_rd_dvld), 64'(0));
      chk("mid_abandon_err", 64'(rd_err), 64'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
